pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It generates the stall and flush controls consumed by the IF stage (stall_id, flush_id), by pc_gen and by the ID/EX register. It detects load-use hazards, redirects on taken branches, sequences multi-cycle mul/div occupancy of EX, and supports a debug halt handshake. It also keeps a stall-cycle performance counter.

Parameters:
MD_LAT, 4, number of cycles a mul/div op occupies EX (valid range 2..16)
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
rs1_id  input  5  rs1 index of the instruction in ID
rs2_id  input  5  rs2 index of the instruction in ID
rs1_used_id  input  1  ID instruction reads rs1
rs2_used_id  input  1  ID instruction reads rs2
rd_ex  input  5  destination register of the instruction in EX
mem_read_ex  input  1  EX instruction is a load
branch_taken_ex  input  1  EX resolved a taken branch or jump
md_start_ex  input  1  a mul/div op entered EX this cycle (1-cycle pulse)
halt_req  input  1  debug halt request (level)
stall_pc  output  1  hold the PC register
stall_id  output  1  hold the IF/ID register
flush_id  output  1  load NOP into the IF/ID register
stall_ex  output  1  hold the ID/EX register
flush_ex  output  1  load a bubble into the ID/EX register
pc_sel  output  1  1 = pc_gen selects the branch target
halt_ack  output  1  core is halted
stall_cnt  output  CNT_W  count of cycles with stall_pc=1

Behaviour:
- Reset: rst is synchronous and active-high, sampled on the rising edge of clk. It forces state RUN, md_cnt=0 and stall_cnt=0. While rst=1, all 1-bit outputs are 0.
- The state register and the counters are updated on the clock edge. All control outputs are combinational from state plus the current-cycle inputs, so the stages act on them at the same edge.
- State RUN. Conditions are evaluated in priority order:
  1. branch_taken_ex=1: pc_sel=1, flush_id=1, flush_ex=1, no stalls. md_start_ex is ignored in the same cycle.
  2. md_start_ex=1: stall_pc=1, stall_id=1, stall_ex=1. Load md_cnt=MD_LAT-2. Go to MD_BUSY.
  3. Load-use hazard: mem_read_ex=1, rd_ex!=0, and ((rs1_used_id and rs1_id==rd_ex) or (rs2_used_id and rs2_id==rd_ex)). Assert stall_pc, stall_id and flush_ex for exactly 1 cycle.
  4. Otherwise all outputs are 0.
  - halt_req=1 in RUN: the priority action above is applied in the current cycle, then the next state is HALT.
- State MD_BUSY:
  - stall_pc, stall_id and stall_ex are held at 1. md_cnt decrements by 1 each cycle.
  - When md_cnt==0, the stalls are still asserted in that cycle and the next state is RUN (or HALT if halt_req=1).
  - Total EX occupancy is exactly MD_LAT cycles.
  - branch_taken_ex, load-use and md_start_ex are ignored.
- State HALT:
  - stall_pc, stall_id and stall_ex are 1. halt_ack=1 from the first HALT cycle.
  - When halt_req falls, the next state is RUN with halt_ack=0. Hazards are re-evaluated normally in the first RUN cycle.
- Register x0 never creates a hazard.
- stall_cnt increments on every edge where stall_pc=1 and rst=0. It wraps modulo 2^CNT_W.
- Reset asserted mid-MD_BUSY or mid-HALT aborts the operation immediately. The next cycle is RUN with all outputs 0.
- flush and stall never both assert for the same register. flush_id implies stall_id=0, and flush_ex implies stall_ex=0.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> stall_pc=stall_id=flush_ex=1 for 1 cycle; stall_cnt 0->1. Same inputs with rd_ex=0 -> no stall.
- Branch plus hazard in the same cycle: branch_taken_ex=1 with a load-use match -> pc_sel=flush_id=flush_ex=1, stall_pc=0, stall_cnt unchanged.
- Mul/div with MD_LAT=4: md_start_ex pulse -> stall_pc/stall_id/stall_ex high for exactly 4 consecutive cycles, then 0; stall_cnt +4. A branch_taken_ex pulse during the busy window -> ignored.
- Halt during mul/div: halt_req rises in the 2nd busy cycle -> MD finishes its 4 cycles, then halt_ack=1 with stalls held. halt_req falls -> halt_ack=0 next cycle and stalls release.
- Reset mid-busy: rst=1 in the 2nd MD_BUSY cycle -> the next cycle has all outputs 0, stall_cnt=0, state RUN.
- Counter wrap with CNT_W=4: 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs from the pipeline and stall/flush controls back to it.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, md_start_ex, halt_req;
    logic stall_pc, stall_id, flush_id, stall_ex, flush_ex, pc_sel, halt_ack;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_read_ex,
               branch_taken_ex, md_start_ex, halt_req,
        input  stall_pc, stall_id, flush_id, stall_ex, flush_ex, pc_sel, halt_ack, stall_cnt
    );
    modport slave (
        input  rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_read_ex,
               branch_taken_ex, md_start_ex, halt_req,
        output stall_pc, stall_id, flush_id, stall_ex, flush_ex, pc_sel, halt_ack, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush generation for load-use, taken branches, mul/div occupancy and debug halt.
module pipe_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input logic clk,
    input logic rst,
    pipe_ctrl_if.slave p
);
    typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;
    state_t state, state_nx;
    logic [3:0] md_cnt, md_cnt_nx;
    logic load_use;
    assign load_use = p.mem_read_ex && p.rd_ex != 5'd0 &&
                      ((p.rs1_used_id && p.rs1_id == p.rd_ex) || (p.rs2_used_id && p.rs2_id == p.rd_ex));
    always_comb begin
        {p.stall_pc, p.stall_id, p.flush_id, p.stall_ex, p.flush_ex, p.pc_sel, p.halt_ack} = '0;
        state_nx = state;
        md_cnt_nx = md_cnt;
        case (state)
            RUN: begin
                if (p.branch_taken_ex)
                    {p.pc_sel, p.flush_id, p.flush_ex} = 3'b111;
                else if (p.md_start_ex) begin
                    {p.stall_pc, p.stall_id, p.stall_ex} = 3'b111;
                    md_cnt_nx = 4'(MD_LAT - 2);
                end else if (load_use)
                    {p.stall_pc, p.stall_id, p.flush_ex} = 3'b111;
                // an accepted mul/div must finish its occupancy before a halt can take effect
                state_nx = (!p.branch_taken_ex && p.md_start_ex) ? MD_BUSY : p.halt_req ? HALT : RUN;
            end
            MD_BUSY: begin
                {p.stall_pc, p.stall_id, p.stall_ex} = 3'b111;
                md_cnt_nx = md_cnt - 4'd1;
                state_nx = md_cnt != 4'd0 ? MD_BUSY : p.halt_req ? HALT : RUN;
            end
            HALT: begin
                {p.stall_pc, p.stall_id, p.stall_ex, p.halt_ack} = 4'b1111;
                state_nx = p.halt_req ? HALT : RUN;
            end
            default: state_nx = RUN;
        endcase
        if (rst)
            {p.stall_pc, p.stall_id, p.flush_id, p.stall_ex, p.flush_ex, p.pc_sel, p.halt_ack} = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            md_cnt <= '0;
            p.stall_cnt <= '0;
        end else begin
            state <= state_nx;
            md_cnt <= md_cnt_nx;
            if (p.stall_pc)
                p.stall_cnt <= p.stall_cnt + CNT_W'(1);
        end
    end
endmodule
